// File: rtl/rank_dispatch_if.sv
// Descriptor, engine and result bus of the rank dispatcher.
// The slave modport is the dispatcher's view; master is the surrounding logic.
interface rank_dispatch_if #(
  parameter int META_WIDTH        = 16,
  parameter int FLOW_ID_WIDTH     = 16,
  parameter int FLOW_WEIGHT_WIDTH = 8,
  parameter int RANK_WIDTH        = 16,
  parameter int NUM_RANK_OPS      = 4,
  parameter int RANK_CODE_BITS    = 2
);
  logic                                      busy;
  logic                                      insert;
  logic [RANK_CODE_BITS-1:0]                 rank_op_in;
  logic [META_WIDTH-1:0]                     meta_in;
  logic [FLOW_ID_WIDTH-1:0]                  flowID_in;
  logic [FLOW_WEIGHT_WIDTH-1:0]              flow_weight_in;
  logic [NUM_RANK_OPS-1:0]                   eng_busy;
  logic [NUM_RANK_OPS-1:0]                   eng_insert;
  logic [NUM_RANK_OPS*META_WIDTH-1:0]        eng_meta_in;
  logic [NUM_RANK_OPS*FLOW_ID_WIDTH-1:0]     eng_flowID_in;
  logic [NUM_RANK_OPS*FLOW_WEIGHT_WIDTH-1:0] eng_flow_weight_in;
  logic [NUM_RANK_OPS-1:0]                   eng_valid_out;
  logic [NUM_RANK_OPS-1:0]                   eng_remove;
  logic [NUM_RANK_OPS*RANK_WIDTH-1:0]        eng_rank_out;
  logic [NUM_RANK_OPS*META_WIDTH-1:0]        eng_meta_out;
  logic                                      remove;
  logic                                      valid_out;
  logic [RANK_WIDTH-1:0]                     rank_out;
  logic [META_WIDTH-1:0]                     meta_out;
  logic [31:0]                               drop_count;

  modport slave (
    output busy, eng_insert, eng_meta_in, eng_flowID_in, eng_flow_weight_in,
    output eng_remove, valid_out, rank_out, meta_out, drop_count,
    input  insert, rank_op_in, meta_in, flowID_in, flow_weight_in,
    input  eng_busy, eng_valid_out, eng_rank_out, eng_meta_out, remove
  );

  modport master (
    input  busy, eng_insert, eng_meta_in, eng_flowID_in, eng_flow_weight_in,
    input  eng_remove, valid_out, rank_out, meta_out, drop_count,
    output insert, rank_op_in, meta_in, flowID_in, flow_weight_in,
    output eng_busy, eng_valid_out, eng_rank_out, eng_meta_out, remove
  );
endinterface

// File: rtl/rank_dispatch.sv
// Rank dispatcher: input FIFO steering descriptors to rank engines by op code,
// and an arbiter collecting engine results into a back-pressured output FIFO.
module rank_dispatch #(
  parameter int META_WIDTH        = 16,
  parameter int FLOW_ID_WIDTH     = 16,
  parameter int FLOW_WEIGHT_WIDTH = 8,
  parameter int RANK_WIDTH        = 16,
  parameter int NUM_RANK_OPS      = 4,
  parameter int RANK_CODE_BITS    = 2,
  parameter int L2_IN_DEPTH       = 4,
  parameter int L2_OUT_DEPTH      = 4,
  parameter int ARB_MODE          = 1
) (
  input logic           clk,
  input logic           rst,
  rank_dispatch_if.slave bus
);
  localparam int IN_DEPTH  = 2 ** L2_IN_DEPTH;
  localparam int OUT_DEPTH = 2 ** L2_OUT_DEPTH;
  localparam int DESC_W    = RANK_CODE_BITS + META_WIDTH + FLOW_ID_WIDTH + FLOW_WEIGHT_WIDTH;
  localparam int RES_W     = RANK_WIDTH + META_WIDTH;

  typedef logic [L2_IN_DEPTH:0]      in_cnt_t;
  typedef logic [L2_OUT_DEPTH:0]     out_cnt_t;
  typedef logic [RANK_CODE_BITS-1:0] op_t;

  logic [DESC_W-1:0]           in_mem [IN_DEPTH];
  logic [L2_IN_DEPTH-1:0]      in_wr_ptr_reg, in_rd_ptr_reg;
  in_cnt_t                     in_count_reg;
  logic                        in_empty, in_full, op_legal, in_wr, in_pop;
  op_t                         head_op;
  logic [META_WIDTH-1:0]       head_meta;
  logic [FLOW_ID_WIDTH-1:0]    head_flow;
  logic [FLOW_WEIGHT_WIDTH-1:0] head_weight;
  logic [NUM_RANK_OPS-1:0]     disp_sel;

  logic [RES_W-1:0]            out_mem [OUT_DEPTH];
  logic [L2_OUT_DEPTH-1:0]     out_wr_ptr_reg, out_rd_ptr_reg;
  out_cnt_t                    out_count_reg;
  logic                        out_empty, out_full, out_rd;
  logic [RANK_WIDTH-1:0]       out_head_rank;
  logic [META_WIDTH-1:0]       out_head_meta;

  op_t                         rr_ptr_reg;
  op_t                         arb_start;
  logic [NUM_RANK_OPS-1:0]     eligible, grant_oh;
  logic [2*NUM_RANK_OPS-1:0]   elig_dbl;
  logic                        grant_valid;
  int                          grant_off, grant_idx, rr_next;
  logic [RANK_WIDTH-1:0]       grant_rank;
  logic [META_WIDTH-1:0]       grant_meta;
  logic [31:0]                 drop_count_reg;

  // ---------------- input FIFO ----------------
  assign in_empty = (in_count_reg == '0);
  assign in_full  = (in_count_reg == in_cnt_t'(IN_DEPTH));
  assign op_legal = (32'(bus.rank_op_in) < 32'(NUM_RANK_OPS));
  assign in_wr    = bus.insert & op_legal & ~in_full;
  assign bus.busy = (in_count_reg >= in_cnt_t'(IN_DEPTH - 1));
  assign {head_op, head_meta, head_flow, head_weight} = in_mem[in_rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (in_wr)
      in_mem[in_wr_ptr_reg] <= {bus.rank_op_in, bus.meta_in, bus.flowID_in, bus.flow_weight_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wr_ptr_reg  <= '0;
      in_rd_ptr_reg  <= '0;
      in_count_reg   <= '0;
      drop_count_reg <= '0;
    end else begin
      if (in_wr)  in_wr_ptr_reg <= in_wr_ptr_reg + 1'b1;
      if (in_pop) in_rd_ptr_reg <= in_rd_ptr_reg + 1'b1;
      if (in_wr && !in_pop)      in_count_reg <= in_count_reg + 1'b1;
      else if (!in_wr && in_pop) in_count_reg <= in_count_reg - 1'b1;
      if (bus.insert && !in_wr && !(&drop_count_reg))
        drop_count_reg <= drop_count_reg + 32'd1;
    end
  end

  assign bus.drop_count = drop_count_reg;
  assign in_pop = |disp_sel;

  // Per-engine steering; the head stalls while its target engine is busy.
  for (genvar gi = 0; gi < NUM_RANK_OPS; gi++) begin : g_eng
    assign disp_sel[gi] = ~in_empty & (head_op == op_t'(gi)) & ~bus.eng_busy[gi];
    assign bus.eng_insert[gi] = disp_sel[gi];
    assign bus.eng_meta_in[gi*META_WIDTH +: META_WIDTH] =
      disp_sel[gi] ? head_meta : '0;
    assign bus.eng_flowID_in[gi*FLOW_ID_WIDTH +: FLOW_ID_WIDTH] =
      disp_sel[gi] ? head_flow : '0;
    assign bus.eng_flow_weight_in[gi*FLOW_WEIGHT_WIDTH +: FLOW_WEIGHT_WIDTH] =
      disp_sel[gi] ? head_weight : '0;
    assign grant_oh[gi] = grant_valid & (grant_idx == gi);
  end

  // ---------------- collection arbiter ----------------
  assign out_full = (out_count_reg == out_cnt_t'(OUT_DEPTH));
  // rst gating keeps eng_remove low while reset is held, whatever the engines show.
  assign eligible = bus.eng_valid_out & {NUM_RANK_OPS{~out_full & ~rst}};
  assign bus.eng_remove = grant_oh;

  always_comb begin
    arb_start   = (ARB_MODE == 1) ? rr_ptr_reg : '0;
    elig_dbl    = {eligible, eligible} >> arb_start;
    grant_valid = 1'b0;
    grant_off   = 0;
    for (int i = 0; i < NUM_RANK_OPS; i++) begin
      if (!grant_valid && elig_dbl[i]) begin
        grant_valid = 1'b1;
        grant_off   = i;
      end
    end
    grant_idx = int'(arb_start) + grant_off;
    if (grant_idx >= NUM_RANK_OPS) grant_idx = grant_idx - NUM_RANK_OPS;
    rr_next = (grant_idx == NUM_RANK_OPS - 1) ? 0 : grant_idx + 1;
  end

  always_comb begin
    grant_rank = '0;
    grant_meta = '0;
    for (int i = 0; i < NUM_RANK_OPS; i++) begin
      if (grant_oh[i]) begin
        grant_rank = bus.eng_rank_out[i*RANK_WIDTH +: RANK_WIDTH];
        grant_meta = bus.eng_meta_out[i*META_WIDTH +: META_WIDTH];
      end
    end
  end

  // ---------------- output FIFO ----------------
  assign out_empty = (out_count_reg == '0);
  assign out_rd    = bus.remove & ~out_empty;
  assign {out_head_rank, out_head_meta} = out_mem[out_rd_ptr_reg];
  assign bus.valid_out = ~out_empty;
  assign bus.rank_out  = out_empty ? '0 : out_head_rank;
  assign bus.meta_out  = out_empty ? '0 : out_head_meta;

  always_ff @(posedge clk) begin
    if (grant_valid)
      out_mem[out_wr_ptr_reg] <= {grant_rank, grant_meta};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_count_reg  <= '0;
      rr_ptr_reg     <= '0;
    end else begin
      if (grant_valid) begin
        out_wr_ptr_reg <= out_wr_ptr_reg + 1'b1;
        rr_ptr_reg     <= op_t'(rr_next);
      end
      if (out_rd) out_rd_ptr_reg <= out_rd_ptr_reg + 1'b1;
      if (grant_valid && !out_rd)      out_count_reg <= out_count_reg + 1'b1;
      else if (!grant_valid && out_rd) out_count_reg <= out_count_reg - 1'b1;
    end
  end
endmodule

// File: tb/tb_rank_dispatch.sv
// Bench for rank_dispatch: queue-based reference model with behavioural engines
// on a 4-engine round-robin instance, plus directed checks on a 3-engine fixed-priority one.
module tb_rank_dispatch;
  localparam int N  = 4;
  localparam int NB = 3;
  localparam int D  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  rank_dispatch_if #(.NUM_RANK_OPS(N),  .RANK_CODE_BITS(2)) ifa ();
  rank_dispatch_if #(.NUM_RANK_OPS(NB), .RANK_CODE_BITS(2)) ifb ();

  rank_dispatch #(.NUM_RANK_OPS(N),  .RANK_CODE_BITS(2), .ARB_MODE(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  rank_dispatch #(.NUM_RANK_OPS(NB), .RANK_CODE_BITS(2), .ARB_MODE(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] meta;
    logic [15:0] flow;
    logic [7:0]  wt;
  } desc_t;

  typedef struct {
    logic [15:0] rank;
    logic [15:0] meta;
    int          ready;
  } res_t;

  desc_t       in_q[$];
  res_t        out_q[$];
  res_t        eq[N][$];
  int          p = 0;
  logic [31:0] m_drops = '0;
  int          cyc = 0;
  bit          env_auto = 1'b1;
  int          busy_pct = 0;
  int          rem_pct = 0;
  int          lat[N] = '{1, 2, 3, 4};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] rank_of(input desc_t d);
    return (d.flow + 16'(d.wt) * 16'd3) ^ {d.meta[7:0], d.meta[15:8]};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One clock cycle of dut_a against the model: drive engines, check, then advance.
  task automatic cycle_a();
    logic [3:0]  e_ins, e_rem;
    logic [63:0] e_meta, e_flow;
    logic [31:0] e_wt;
    bit          disp, acc_in;
    int          g, op;
    desc_t       d;
    if (env_auto) begin
      for (int k = 0; k < N; k++) begin
        ifa.eng_busy[k]      = ($urandom_range(99) < busy_pct) || (eq[k].size() >= 4);
        ifa.eng_valid_out[k] = (eq[k].size() > 0) && (eq[k][0].ready <= cyc);
        ifa.eng_rank_out[k*16 +: 16] = ifa.eng_valid_out[k] ? eq[k][0].rank : 16'($urandom);
        ifa.eng_meta_out[k*16 +: 16] = ifa.eng_valid_out[k] ? eq[k][0].meta : 16'($urandom);
      end
    end
    #1;
    e_ins = '0; e_meta = '0; e_flow = '0; e_wt = '0; op = 0;
    disp = (in_q.size() > 0) && !ifa.eng_busy[in_q[0].op];
    if (disp) begin
      op = int'(in_q[0].op);
      e_ins[op] = 1'b1;
      e_meta[op*16 +: 16] = in_q[0].meta;
      e_flow[op*16 +: 16] = in_q[0].flow;
      e_wt[op*8 +: 8]     = in_q[0].wt;
    end
    g = -1;
    if (out_q.size() < D)
      for (int i = 0; i < N; i++)
        if (g < 0 && ifa.eng_valid_out[(p + i) % N]) g = (p + i) % N;
    e_rem = (g >= 0) ? 4'(1 << g) : 4'd0;

    chk("busy",        ifa.busy,               64'(in_q.size() >= D - 1));
    chk("eng_insert",  ifa.eng_insert,         e_ins);
    chk("eng_meta_in", ifa.eng_meta_in,        e_meta);
    chk("eng_flow_in", ifa.eng_flowID_in,      e_flow);
    chk("eng_wt_in",   ifa.eng_flow_weight_in, e_wt);
    chk("eng_remove",  ifa.eng_remove,         e_rem);
    chk("valid_out",   ifa.valid_out,          64'(out_q.size() > 0));
    chk("rank_out",    ifa.rank_out,           (out_q.size() > 0) ? out_q[0].rank : 16'd0);
    chk("meta_out",    ifa.meta_out,           (out_q.size() > 0) ? out_q[0].meta : 16'd0);
    chk("drop_count",  ifa.drop_count,         m_drops);

    @(posedge clk);
    acc_in = ifa.insert && (int'(ifa.rank_op_in) < N) && (in_q.size() < D);
    if (ifa.insert && !acc_in && m_drops != 32'hFFFF_FFFF) m_drops++;
    if (disp) begin
      d = in_q.pop_front();
      if (env_auto) eq[d.op].push_back('{rank_of(d), d.meta, cyc + lat[d.op]});
    end
    if (acc_in) in_q.push_back('{ifa.rank_op_in, ifa.meta_in, ifa.flowID_in, ifa.flow_weight_in});
    if (ifa.remove && out_q.size() > 0) void'(out_q.pop_front());
    if (g >= 0) begin
      out_q.push_back('{ifa.eng_rank_out[g*16 +: 16], ifa.eng_meta_out[g*16 +: 16], 0});
      if (env_auto) void'(eq[g].pop_front());
      p = (g + 1) % N;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_rand(input int n, input int ins_pct);
    for (int i = 0; i < n; i++) begin
      ifa.insert         = ($urandom_range(99) < ins_pct);
      ifa.rank_op_in     = 2'($urandom_range(N - 1));
      ifa.meta_in        = 16'($urandom);
      ifa.flowID_in      = 16'($urandom);
      ifa.flow_weight_in = 8'($urandom);
      ifa.remove         = ($urandom_range(99) < rem_pct);
      cycle_a();
    end
  endtask

  initial begin
    ifa.insert = 0; ifa.rank_op_in = '0; ifa.meta_in = '0; ifa.flowID_in = '0;
    ifa.flow_weight_in = '0; ifa.eng_busy = '0; ifa.eng_valid_out = '0;
    ifa.eng_rank_out = '0; ifa.eng_meta_out = '0; ifa.remove = 0;
    ifb.insert = 0; ifb.rank_op_in = '0; ifb.meta_in = '0; ifb.flowID_in = '0;
    ifb.flow_weight_in = '0; ifb.eng_busy = '0; ifb.eng_valid_out = '0;
    ifb.eng_rank_out = '0; ifb.eng_meta_out = '0; ifb.remove = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state, then a single op-2 descriptor through the 3-cycle engine.
    cycle_a();
    ifa.insert = 1; ifa.rank_op_in = 2'd2; ifa.meta_in = 16'h00AA;
    ifa.flowID_in = 16'd5; ifa.flow_weight_in = 8'd3;
    cycle_a();
    ifa.insert = 0;
    repeat (5) cycle_a();
    ifa.remove = 1;
    cycle_a();
    ifa.remove = 0;
    cycle_a();

    // Fixed-priority three-engine instance: illegal op, dispatch, priority, fill.
    #1;
    chk("b_reset_drop",  ifb.drop_count, 32'd0);
    chk("b_reset_valid", ifb.valid_out,  1'b0);
    ifb.insert = 1; ifb.rank_op_in = 2'd3; ifb.meta_in = 16'h0001;
    tick();
    ifb.insert = 0; #1;
    chk("b_illegal_drop",  ifb.drop_count, 32'd1);
    chk("b_illegal_noins", ifb.eng_insert, 3'b000);
    ifb.insert = 1; ifb.rank_op_in = 2'd1; ifb.meta_in = 16'h1234;
    ifb.flowID_in = 16'h0007; ifb.flow_weight_in = 8'h09;
    tick();
    ifb.insert = 0; #1;
    chk("b_dispatch",  ifb.eng_insert,         3'b010);
    chk("b_meta_sl",   ifb.eng_meta_in,        48'h0000_1234_0000);
    chk("b_flow_sl",   ifb.eng_flowID_in,      48'h0000_0007_0000);
    chk("b_wt_sl",     ifb.eng_flow_weight_in, 24'h00_09_00);
    tick();
    ifb.eng_valid_out = 3'b111;
    ifb.eng_rank_out = {16'd3, 16'd2, 16'd1};
    ifb.eng_meta_out = {16'hC, 16'hB, 16'hA};
    #1;
    chk("b_fixed_pri0", ifb.eng_remove, 3'b001);
    tick(); #1;
    chk("b_fixed_pri1", ifb.eng_remove, 3'b001);
    chk("b_valid_out",  ifb.valid_out,  1'b1);
    chk("b_rank_head",  ifb.rank_out,   16'd1);
    chk("b_meta_head",  ifb.meta_out,   16'hA);
    ifb.eng_valid_out = 3'b110; #1;
    chk("b_fixed_pri2", ifb.eng_remove, 3'b010);
    tick();
    ifb.eng_valid_out = 3'b000; ifb.remove = 1; #1;
    chk("b_no_grant", ifb.eng_remove, 3'b000);
    tick(); #1;
    chk("b_rank_next", ifb.rank_out, 16'd2);
    chk("b_meta_next", ifb.meta_out, 16'hB);
    tick();
    ifb.remove = 0; #1;
    chk("b_drained_valid", ifb.valid_out, 1'b0);
    chk("b_drained_rank",  ifb.rank_out,  16'd0);
    ifb.eng_busy = '1;
    for (int i = 0; i < 15; i++) begin
      chk("b_fill_busy_low", ifb.busy, 1'b0);
      ifb.insert = 1; ifb.rank_op_in = 2'(i % NB); ifb.meta_in = 16'(i);
      tick(); #1;
    end
    ifb.insert = 0; #1;
    chk("b_busy_at_15", ifb.busy, 1'b1);
    ifb.insert = 1; tick(); #1;
    chk("b_16th_accepted", ifb.drop_count, 32'd1);
    tick(); #1;
    ifb.insert = 0;
    chk("b_17th_dropped", ifb.drop_count, 32'd2);
    chk("b_stalled",      ifb.eng_insert, 3'b000);

    // Randomized traffic against the model.
    busy_pct = 30; rem_pct = 60; run_rand(300, 70);
    busy_pct = 85; rem_pct = 20; run_rand(200, 90);
    busy_pct = 20; rem_pct = 70; run_rand(200, 50);

    // Asynchronous reset between edges with traffic still applied.
    env_auto = 0;
    ifa.eng_busy = '0; ifa.eng_valid_out = '1; ifa.insert = 1;
    #2 rst = 1'b1;
    #1;
    chk("rst_busy",       ifa.busy,               1'b0);
    chk("rst_valid_out",  ifa.valid_out,          1'b0);
    chk("rst_eng_insert", ifa.eng_insert,         4'b0);
    chk("rst_eng_remove", ifa.eng_remove,         4'b0);
    chk("rst_eng_meta",   ifa.eng_meta_in,        64'd0);
    chk("rst_eng_flow",   ifa.eng_flowID_in,      64'd0);
    chk("rst_eng_wt",     ifa.eng_flow_weight_in, 32'd0);
    chk("rst_rank_out",   ifa.rank_out,           16'd0);
    chk("rst_meta_out",   ifa.meta_out,           16'd0);
    chk("rst_drop_count", ifa.drop_count,         32'd0);
    chk("rst_b_remove",   ifb.eng_remove,         3'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    ifa.insert = 0; ifa.remove = 0;
    in_q.delete(); out_q.delete();
    for (int k = 0; k < N; k++) eq[k].delete();
    p = 0; m_drops = '0;

    // Round robin from engine 0 with every engine valid, until the output fills.
    ifa.eng_valid_out = 4'b1111;
    ifa.eng_rank_out = {16'h0D03, 16'h0D02, 16'h0D01, 16'h0D00};
    ifa.eng_meta_out = {16'hE003, 16'hE002, 16'hE001, 16'hE000};
    repeat (20) cycle_a();
    ifa.remove = 1;
    cycle_a();
    ifa.remove = 0;
    repeat (2) cycle_a();

    // Head-of-line stall: op 1 waits on a busy engine, op 0 waits behind it.
    ifa.eng_valid_out = 4'b0000; ifa.eng_busy = 4'b0010;
    ifa.insert = 1; ifa.rank_op_in = 2'd1; ifa.meta_in = 16'h0101;
    ifa.flowID_in = 16'h0011; ifa.flow_weight_in = 8'h21;
    cycle_a();
    ifa.rank_op_in = 2'd0; ifa.meta_in = 16'h0100;
    ifa.flowID_in = 16'h0010; ifa.flow_weight_in = 8'h20;
    cycle_a();
    ifa.insert = 0;
    repeat (3) cycle_a();
    ifa.eng_busy = 4'b0000;
    repeat (3) cycle_a();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
